// File: rtl/inst_decode_queue_pkg.sv
// ============================================================================
// Module   : inst_decode_queue_pkg
// Brief    : Shared constants, bus widths and state encoding for the IF->ID queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_decode_queue_pkg;

  localparam int c_DEFAULT_DEPTH = 4;
  localparam int c_ADDR_W        = 32;
  localparam int c_INST_W        = 32;

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_WAIT_DS = 1'b1
  } dq_state_t;

endpackage

`default_nettype wire

// File: rtl/id_queue_mem.sv
// ============================================================================
// Module   : id_queue_mem
// Brief    : DEPTH x WIDTH register array, one write port, two async read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_queue_mem #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 65,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_ptr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [PTR_W-1:0] i_rd0_ptr,
  output logic [WIDTH-1:0] o_rd0_data,
  input  logic [PTR_W-1:0] i_rd1_ptr,
  output logic [WIDTH-1:0] o_rd1_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Payload storage carries no reset; occupancy is tracked by the queue control.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd0_data = r_mem[i_rd0_ptr];
  assign o_rd1_data = r_mem[i_rd1_ptr];

endmodule

`default_nettype wire

// File: rtl/inst_decode_queue.sv
// ============================================================================
// Module   : inst_decode_queue
// Brief    : Circular IF->ID instruction queue with branch delay-slot tracking.
//            Optional same-cycle bypass when empty: define ID_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_decode_queue
  import inst_decode_queue_pkg::*;
#(
  parameter int DEPTH  = c_DEFAULT_DEPTH,
  parameter int ADDR_W = c_ADDR_W,
  parameter int INST_W = c_INST_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [INST_W-1:0]          out_inst,
  output logic                       out_delayslot_flag,
  input  logic                       id_ready,
  input  logic                       branch_flag,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + INST_W + 1;

  localparam logic [CNT_W-1:0] c_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_TWO = CNT_W'(2);
  localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

  dq_state_t        r_state, w_state_nxt;
  logic [PTR_W-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt, w_head_p1;
  logic [CNT_W-1:0] r_count, w_count_nxt;

  logic             w_empty, w_push, w_pop, w_bypass, w_bypass_pop;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [ENT_W-1:0] w_wr_data, w_head_ent, w_next_ent;

  id_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk        (clk),
    .i_wr_en    (w_wr_en),
    .i_wr_ptr   (w_wr_ptr),
    .i_wr_data  (w_wr_data),
    .i_rd0_ptr  (r_head),
    .o_rd0_data (w_head_ent),
    .i_rd1_ptr  (w_head_p1),
    .o_rd1_data (w_next_ent)
  );

  assign w_head_p1 = r_head + c_PTR_ONE;
  assign w_empty   = (r_count == '0);
  assign in_ready  = !rst && (r_count != c_FULL);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = !w_empty && id_ready;
  assign count     = r_count;

`ifdef ID_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && in_valid && !flush && !rst;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_bypass_pop = w_bypass && id_ready;

  always_comb begin
    out_valid          = !w_empty;
    out_addr           = w_head_ent[ENT_W-1 -: ADDR_W];
    out_inst           = w_head_ent[INST_W:1];
    out_delayslot_flag = w_head_ent[0] && !w_empty;
    if (w_bypass) begin
      out_valid          = 1'b1;
      out_addr           = in_addr;
      out_inst           = in_inst;
      out_delayslot_flag = (r_state == ST_WAIT_DS);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    w_wr_en     = 1'b0;
    w_wr_ptr    = r_tail;
    w_wr_data   = {in_addr, in_inst, (r_state == ST_WAIT_DS)};

    if (flush) begin
      w_state_nxt = ST_NORMAL;
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end else if (w_bypass_pop) begin
      // Bypassed word went straight to ID; a taken branch leaves its slot pending.
      w_state_nxt = branch_flag ? ST_WAIT_DS : ST_NORMAL;
    end else if (w_pop && branch_flag) begin
      if (r_count >= c_CNT_TWO) begin
        // Only the delay slot survives; rewrite it in place with ds set.
        w_wr_en     = 1'b1;
        w_wr_ptr    = w_head_p1;
        w_wr_data   = {w_next_ent[ENT_W-1:1], 1'b1};
        w_head_nxt  = w_head_p1;
        w_tail_nxt  = w_head_p1 + c_PTR_ONE;
        w_count_nxt = c_CNT_ONE;
      end else if (w_push) begin
        w_wr_en     = 1'b1;
        w_wr_data   = {in_addr, in_inst, 1'b1};
        w_head_nxt  = w_head_p1;
        w_tail_nxt  = r_tail + c_PTR_ONE;
        w_count_nxt = c_CNT_ONE;
      end else begin
        w_head_nxt  = w_head_p1;
        w_count_nxt = '0;
        w_state_nxt = ST_WAIT_DS;
      end
    end else begin
      if (w_push) begin
        w_wr_en     = 1'b1;
        w_tail_nxt  = r_tail + c_PTR_ONE;
        w_state_nxt = ST_NORMAL;
      end
      if (w_pop) begin
        w_head_nxt = w_head_p1;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + c_CNT_ONE;
        2'b01:   w_count_nxt = r_count - c_CNT_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_NORMAL;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_decode_queue.sv
// ============================================================================
// Module   : tb_inst_decode_queue
// Brief    : Directed self-checking bench for inst_decode_queue (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_addr;
  logic [31:0] out_inst;
  logic        out_delayslot_flag;
  logic        id_ready;
  logic        branch_flag;
  logic        flush;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  inst_decode_queue #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_addr            (in_addr),
    .in_inst            (in_inst),
    .in_ready           (in_ready),
    .out_valid          (out_valid),
    .out_addr           (out_addr),
    .out_inst           (out_inst),
    .out_delayslot_flag (out_delayslot_flag),
    .id_ready           (id_ready),
    .branch_flag        (branch_flag),
    .flush              (flush),
    .count              (count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] a, input logic rdy,
                       input logic br, input logic fl);
    in_valid    = v;
    in_addr     = a;
    in_inst     = ~a;
    id_ready    = rdy;
    branch_flag = br;
    flush       = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
    #12;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_delayslot_flag !== 1'b0) begin bad++; $display("FAIL reset_ds: got %b want 0", out_delayslot_flag); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step();
    end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    drive(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
    step();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_refused_count: got %0d want 4", count); end
    total++; if (out_addr !== 32'h100) begin bad++; $display("FAIL full_head: got %h want 00000100", out_addr); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop_count: got %0d want 3", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_in_ready: got %b want 1", in_ready); end
    total++; if (out_addr !== 32'h104 || out_delayslot_flag !== 1'b0) begin bad++; $display("FAIL full_pop_head: got %h/%b want 00000104/0", out_addr, out_delayslot_flag); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL full_flush_count: got %0d want 0", count); end
  endtask

  task automatic test_branch_multi();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step();
    end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL brm_fill_count: got %0d want 3", count); end
    drive(1'b1, 32'h20C, 1'b1, 1'b1, 1'b0);
    #1;
    total++; if (out_addr !== 32'h200) begin bad++; $display("FAIL brm_head_before: got %h want 00000200", out_addr); end
    step();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL brm_count: got %0d want 1", count); end
    total++; if (out_addr !== 32'h204 || out_inst !== ~32'h204) begin bad++; $display("FAIL brm_head: got %h/%h want 00000204/%h", out_addr, out_inst, ~32'h204); end
    total++; if (out_delayslot_flag !== 1'b1) begin bad++; $display("FAIL brm_ds: got %b want 1", out_delayslot_flag); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL brm_drain: got %0d/%b want 0/0", count, out_valid); end
  endtask

  task automatic test_branch_single();
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL brs_empty: got %0d/%b want 0/0", count, out_valid); end
    drive(1'b1, 32'hBFC0_0010, 1'b0, 1'b0, 1'b0);
    step();
    total++; if (count !== 3'd1 || out_addr !== 32'hBFC0_0010) begin bad++; $display("FAIL brs_ds_push: got %0d/%h want 1/bfc00010", count, out_addr); end
    total++; if (out_delayslot_flag !== 1'b1) begin bad++; $display("FAIL brs_ds_flag: got %b want 1", out_delayslot_flag); end
    drive(1'b1, 32'hBFC0_0014, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (count !== 3'd1 || out_addr !== 32'hBFC0_0014) begin bad++; $display("FAIL brs_pushpop: got %0d/%h want 1/bfc00014", count, out_addr); end
    total++; if (out_delayslot_flag !== 1'b0) begin bad++; $display("FAIL brs_normal_ds: got %b want 0", out_delayslot_flag); end
    drive(1'b1, 32'h400, 1'b1, 1'b1, 1'b0);
    step();
    total++; if (count !== 3'd1 || out_addr !== 32'h400 || out_delayslot_flag !== 1'b1) begin bad++; $display("FAIL brs_one_push: got %0d/%h/%b want 1/00000400/1", count, out_addr, out_delayslot_flag); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL brs_drain: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h50C, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_state: got %0d/%b want 0/0", count, out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    drive(1'b1, 32'h510, 1'b0, 1'b0, 1'b0);
    step();
    total++; if (count !== 3'd1 || out_addr !== 32'h510 || out_delayslot_flag !== 1'b0) begin bad++; $display("FAIL flush_after: got %0d/%h/%b want 1/00000510/0", count, out_addr, out_delayslot_flag); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_branch_ignored();
    drive(1'b1, 32'h600, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    total++; if (count !== 3'd1 || out_addr !== 32'h600 || out_delayslot_flag !== 1'b0) begin bad++; $display("FAIL brig_hold: got %0d/%h/%b want 1/00000600/0", count, out_addr, out_delayslot_flag); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h608, 1'b0, 1'b0, 1'b0);
    step();
    total++; if (out_addr !== 32'h608 || out_delayslot_flag !== 1'b0) begin bad++; $display("FAIL brig_no_ds: got %h/%b want 00000608/0", out_addr, out_delayslot_flag); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 32'(4 * i), 1'b1, 1'b0, 1'b0);
      #1;
      total++; if (out_addr !== 32'(4 * (i - 1))) begin bad++; $display("FAIL wrap_order[%0d]: got %h want %h", i, out_addr, 32'(4 * (i - 1))); end
      step();
      total++; if (count !== 3'd1) begin bad++; $display("FAIL wrap_count[%0d]: got %0d want 1", i, count); end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (out_addr !== 32'h24 || out_inst !== ~32'h24) begin bad++; $display("FAIL wrap_last: got %h/%h want 00000024/%h", out_addr, out_inst, ~32'h24); end
    step();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_drain: got %0d want 0", count); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h704, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL async_rst: got %0d/%b/%b want 0/0/0", count, out_valid, in_ready); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h710, 1'b0, 1'b0, 1'b0);
    step();
    total++; if (count !== 3'd1 || out_addr !== 32'h710) begin bad++; $display("FAIL async_rst_after: got %0d/%h want 1/00000710", count, out_addr); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_bypass();
    drive(1'b1, 32'h800, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef ID_QUEUE_BYPASS_EN
    total++; if (out_valid !== 1'b1 || out_addr !== 32'h800) begin bad++; $display("FAIL bypass_same_cycle: got %b/%h want 1/00000800", out_valid, out_addr); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL bypass_count: got %0d want 0", count); end
`else
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_same_cycle: got %b want 0", out_valid); end
    step();
    total++; if (count !== 3'd1 || out_valid !== 1'b1 || out_addr !== 32'h800) begin bad++; $display("FAIL latency_next: got %0d/%b/%h want 1/1/00000800", count, out_valid, out_addr); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_full();
    test_branch_multi();
    test_branch_single();
    test_flush();
    test_branch_ignored();
    test_wrap();
    test_async_reset();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_decode_queue.md
INST_DECODE_QUEUE -- requirements
Module: inst_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning PC address width.
REQ-003 SHALL have parameter INST_W, default 32, meaning instruction width.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  IF presents an instruction.
REQ-007 SHALL have port in_addr  in  ADDR_W  PC of presented instruction.
REQ-008 SHALL have port in_inst  in  INST_W  presented instruction word.
REQ-009 SHALL have port in_ready  out  1  queue accepts; a push is in_valid && in_ready.
REQ-010 SHALL have port out_valid  out  1  head entry valid for ID.
REQ-011 SHALL have port out_addr  out  ADDR_W  head PC.
REQ-012 SHALL have port out_inst  out  INST_W  head instruction.
REQ-013 SHALL have port out_delayslot_flag  out  1  head is a branch delay slot.
REQ-014 SHALL have port id_ready  in  1  ID consumes head (driven as !stall_request); a pop is out_valid && id_ready.
REQ-015 SHALL have port branch_flag  in  1  ID resolved the popped head as a taken branch.
REQ-016 SHALL have port flush  in  1  exception/eret flush, discards everything.
REQ-017 SHALL have port count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-018 SHALL be a circular buffer; head/tail pointers wrap modulo DEPTH; each entry holds addr, inst, 1-bit ds flag.
REQ-019 SHALL drive in_ready = !rst && (count != DEPTH), derived from registered state only.
REQ-020 SHALL drive out_valid = (count != 0) and head fields combinationally from storage.
REQ-021 SHALL on simultaneous push and pop (non-full) keep count unchanged and advance both pointers.
REQ-022 SHALL implement states NORMAL and WAIT_DS; branch_flag is ignored unless a pop occurs.
REQ-023 SHALL on pop with branch_flag in NORMAL: if count>=2 keep only entry head+1 (ds flag set), drop all other entries and the same-cycle push; if count==1 with a push, keep the push as sole entry, ds set; if count==1 without push, empty and go to WAIT_DS.
REQ-024 SHALL in WAIT_DS store the next accepted push with ds set and return to NORMAL; a pop cannot occur in WAIT_DS (queue empty).
REQ-025 SHALL on flush (dominates pop, push, branch_flag) next cycle set count 0, pointers 0, state NORMAL; the same-cycle push is dropped.
REQ-026 SHALL store non-delay-slot pushes with ds clear.
REQ-027 SHALL require IF to deliver the sequential successor of a branch before the redirected target; the queue does not check this.

Reset
REQ-028 SHALL while rst high: count 0, pointers 0, state NORMAL, out_valid 0, in_ready 0, out_delayslot_flag 0; entry storage need not be cleared.
REQ-029 SHALL on rst mid-operation discard all entries immediately (asynchronous), with no pop or push reported.

Configuration
REQ-030 SHALL with macro ID_QUEUE_BYPASS_EN defined: when count==0 and in_valid, out_valid=1 with in_addr/in_inst same cycle (ds = state==WAIT_DS); if id_ready the instruction is not written; the bypass is disabled while flush is high.
REQ-031 SHALL without ID_QUEUE_BYPASS_EN have minimum push-to-out_valid latency of one cycle.

Structure
REQ-032 SHALL place state encoding (NORMAL=0, WAIT_DS=1) and default DEPTH constant in the shared define header alongside bus widths.
REQ-033 SHALL use one sub-module, id_queue_mem: DEPTH x (ADDR_W+INST_W+1) register array, one write port, two combinational read ports (head, head+1).

Verification
REQ-034 SHALL cover: 4 pushes, id_ready=0 -> count=4, in_ready=0, 5th push refused; then one pop -> count=3, in_ready=1.
REQ-035 SHALL cover: count=3, pop with branch_flag=1 and push -> next cycle count=1, head = old entry 2 with ds=1.
REQ-036 SHALL cover: count=1, pop with branch_flag=1, no push -> count=0, WAIT_DS; next push of addr 0xBFC00010 -> head ds=1, state NORMAL.
REQ-037 SHALL cover: count=3, flush and push and pop same cycle -> count=0, out_valid=0 next cycle.
REQ-038 SHALL cover: pointer wrap: 10 push/pop pairs with DEPTH=4 -> FIFO order preserved, addresses 0x0..0x24 in sequence.
REQ-039 SHALL cover: with ID_QUEUE_BYPASS_EN, empty queue, push with id_ready=1 -> out_valid same cycle, count stays 0.
